// File: rtl/router_fsm_nch.sv
// -----------------------------------------------------------------------------
// router_fsm_nch
// Packet-router control FSM for NUM_CH destination channels. Decodes the
// destination address of each packet, waits for the target FIFO to drain,
// sequences header/payload/parity writes, rides out FIFO-full back-pressure,
// and discards packets addressed to a non-existent channel.
//
// Optional feature: define ROUTER_WAIT_TIMEOUT_EN to bound the dwell in
// WAIT_TILL_EMPTY to WAIT_TIMEOUT cycles. On expiry the packet is dropped and
// timeout_err pulses for one cycle. Without the macro the wait is unbounded
// and timeout_err is tied low.
// -----------------------------------------------------------------------------
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              drop_state,
  output logic              timeout_err
);

  // Elaboration-time legality checks on the parameters.
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("router_fsm_nch: NUM_CH must be in 2..8");
  end
  if (ADDR_W > 4 || (1 << ADDR_W) < NUM_CH) begin : g_bad_addr_w
    $error("router_fsm_nch: ADDR_W must satisfy clog2(NUM_CH) <= ADDR_W <= 4");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 65535) begin : g_bad_timeout
    $error("router_fsm_nch: WAIT_TIMEOUT must be in 1..65535");
  end

  typedef enum logic [3:0] {
    S_DECODE_ADDRESS     = 4'd0,
    S_WAIT_TILL_EMPTY    = 4'd1,
    S_LOAD_FIRST_DATA    = 4'd2,
    S_LOAD_DATA          = 4'd3,
    S_LOAD_PARITY        = 4'd4,
    S_FIFO_FULL_STATE    = 4'd5,
    S_LOAD_AFTER_FULL    = 4'd6,
    S_CHECK_PARITY_ERROR = 4'd7,
    S_DROP_PACKET        = 4'd8
  } state_t;

  // Channel count widened to the address width plus one so the range check
  // also works when NUM_CH is an exact power of two (e.g. 8 with ADDR_W=3).
  localparam logic [ADDR_W:0]   LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);
  localparam logic [NUM_CH-1:0] LP_ONE    = {{(NUM_CH - 1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [NUM_CH-1:0] r_ch_sel;
  logic [NUM_CH-1:0] w_addr_onehot;
  logic              w_addr_ok;
  logic              w_addr_empty;
  logic              w_sel_empty;
  logic              w_soft_hit;
  logic              w_timeout;

  // Live address decode, only meaningful while in DECODE_ADDRESS.
  assign w_addr_ok     = ({1'b0, addr} < LP_NUM_CH);
  assign w_addr_onehot = w_addr_ok ? (LP_ONE << addr) : '0;
  assign w_addr_empty  = |(fifo_empty & w_addr_onehot);

  // Everything after the decode works off the latched channel, never addr.
  assign w_sel_empty = |(fifo_empty & r_ch_sel);

  // A soft reset only matters for the channel this packet is bound to.
  assign w_soft_hit = (r_state != S_DECODE_ADDRESS) && (|(soft_reset & r_ch_sel));

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam logic [15:0] LP_WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  // Expiry is flagged on the WAIT_TIMEOUT-th cycle spent waiting; an empty
  // FIFO on that same cycle still wins and the packet proceeds.
  assign w_timeout = (r_state == S_WAIT_TILL_EMPTY) &&
                     (r_wait_cnt == LP_WAIT_LAST) && !w_sel_empty;

  // Dwell counter: zero on every entry to WAIT_TILL_EMPTY, +1 per cycle there.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT_TILL_EMPTY && w_next_state == S_WAIT_TILL_EMPTY) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // One-cycle error pulse; WAIT->DROP is only reachable through the timeout.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= (r_state == S_WAIT_TILL_EMPTY) && (w_next_state == S_DROP_PACKET);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register with synchronous active-low reset.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_DECODE_ADDRESS;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: soft reset beats timeout, timeout beats normal flow.
  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch is inferred for untaken branches.
  always_comb begin
    w_next_state = r_state;
    if (w_soft_hit) begin
      w_next_state = S_DECODE_ADDRESS;
    end else if (w_timeout) begin
      w_next_state = S_DROP_PACKET;
    end else begin
      unique case (r_state)
        S_DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (!w_addr_ok)        w_next_state = S_DROP_PACKET;
            else if (w_addr_empty) w_next_state = S_LOAD_FIRST_DATA;
            else                   w_next_state = S_WAIT_TILL_EMPTY;
          end
        end
        S_WAIT_TILL_EMPTY: begin
          if (w_sel_empty) w_next_state = S_LOAD_FIRST_DATA;
        end
        S_LOAD_FIRST_DATA: begin
          w_next_state = S_LOAD_DATA;
        end
        S_LOAD_DATA: begin
          if (fifo_full)       w_next_state = S_FIFO_FULL_STATE;
          else if (!pkt_valid) w_next_state = S_LOAD_PARITY;
        end
        S_LOAD_PARITY: begin
          w_next_state = S_CHECK_PARITY_ERROR;
        end
        S_FIFO_FULL_STATE: begin
          if (!fifo_full) w_next_state = S_LOAD_AFTER_FULL;
        end
        S_LOAD_AFTER_FULL: begin
          if (parity_done)        w_next_state = S_DECODE_ADDRESS;
          else if (low_pkt_valid) w_next_state = S_LOAD_PARITY;
          else                    w_next_state = S_LOAD_DATA;
        end
        S_CHECK_PARITY_ERROR: begin
          if (fifo_full) w_next_state = S_FIFO_FULL_STATE;
          else           w_next_state = S_DECODE_ADDRESS;
        end
        S_DROP_PACKET: begin
          if (!pkt_valid) w_next_state = S_DECODE_ADDRESS;
        end
        default: begin
          w_next_state = S_DECODE_ADDRESS;
        end
      endcase
    end
  end

  // Channel latch: captured when leaving DECODE_ADDRESS, cleared on any
  // return to it; a dropped packet captures all-zero.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ch_sel <= '0;
    end else if (w_next_state == S_DECODE_ADDRESS) begin
      r_ch_sel <= '0;
    end else if (r_state == S_DECODE_ADDRESS) begin
      r_ch_sel <= w_addr_onehot;
    end
  end

  assign ch_sel = r_ch_sel;

  // Moore output decode straight from the state register.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    drop_state    = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    unique case (r_state)
      S_DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      S_WAIT_TILL_EMPTY: begin
        busy = 1'b1;
      end
      S_LOAD_FIRST_DATA: begin
        lfd_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      S_LOAD_PARITY: begin
        write_enb_reg = 1'b1;
      end
      S_FIFO_FULL_STATE: begin
        full_state = 1'b1;
      end
      S_LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
      end
      S_DROP_PACKET: begin
        drop_state = 1'b1;
        busy       = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/router_fsm_nch.md
ROUTER_FSM_NCH -- requirements
Module: router_fsm_nch

Interface
REQ-001 SHALL provide parameter NUM_CH, default 3, number of destination channels (legal 2..8).
REQ-002 SHALL provide parameter ADDR_W, default 2, address width; clog2(NUM_CH) <= ADDR_W <= 4.
REQ-003 SHALL provide parameter WAIT_TIMEOUT, default 255, maximum WAIT_TILL_EMPTY dwell in cycles (legal 1..65535).
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 pkt_valid  in  1  source packet-in-progress flag.
REQ-007 addr  in  ADDR_W  destination channel; sampled in DECODE_ADDRESS only.
REQ-008 parity_done  in  1  parity byte written.
REQ-009 low_pkt_valid  in  1  pkt_valid fell while the FIFO was full.
REQ-010 fifo_full  in  1  selected FIFO full.
REQ-011 fifo_empty  in  NUM_CH  per-channel FIFO empty.
REQ-012 soft_reset  in  NUM_CH  per-channel soft reset (read-side timeout).
REQ-013 busy  out  1  source must hold data.
REQ-014 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes.
REQ-015 write_enb_reg  out  1  FIFO write enable.
REQ-016 ch_sel  out  NUM_CH  one-hot latched destination; all-zero when none.
REQ-017 drop_state  out  1  packet being discarded.
REQ-018 timeout_err  out  1  one-cycle pulse on wait timeout.

Function
REQ-019 SHALL implement states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET in one registered state vector.
REQ-020 In DECODE_ADDRESS with pkt_valid=1: addr>=NUM_CH -> DROP_PACKET; else SHALL latch ch_sel=1<<addr and go to LOAD_FIRST_DATA if fifo_empty[addr], otherwise WAIT_TILL_EMPTY; pkt_valid=0 -> stay.
REQ-021 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty of the latched channel is 1, using the latched channel, never live addr.
REQ-022 LOAD_FIRST_DATA SHALL go unconditionally to LOAD_DATA.
REQ-023 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay (fifo_full has priority).
REQ-024 LOAD_PARITY -> CHECK_PARITY_ERROR; FIFO_FULL_STATE -> LOAD_AFTER_FULL when fifo_full=0, else stay.
REQ-025 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-026 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-027 DROP_PACKET SHALL stay while pkt_valid=1 and go to DECODE_ADDRESS on the first cycle pkt_valid=0; write_enb_reg=0 throughout.
REQ-028 busy SHALL be 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET; 1 in all other states.
REQ-029 write_enb_reg SHALL be 1 only in LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
REQ-030 All state-decode outputs, busy and write_enb_reg SHALL be combinational from the state register (zero latency to state); rst_int_reg=1 only in CHECK_PARITY_ERROR.
REQ-031 soft_reset[i] with ch_sel[i]=1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle and clear ch_sel; soft_reset of non-selected channels SHALL be ignored.
REQ-032 Priority SHALL be resetn > soft_reset > timeout > normal transitions.
REQ-033 ch_sel SHALL clear on every entry to DECODE_ADDRESS.

Reset
REQ-034 resetn=0 at a clock edge SHALL set state DECODE_ADDRESS, ch_sel=0, wait counter=0, timeout_err=0, regardless of current state.
REQ-035 After reset outputs SHALL be detect_add=1, busy=0, write_enb_reg=0, all other decodes 0.

Configuration
REQ-036 With ROUTER_WAIT_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT_TILL_EMPTY entry, increment each cycle there, and on reaching WAIT_TIMEOUT with the FIFO still non-empty move to DROP_PACKET and pulse timeout_err for exactly one cycle; an empty FIFO on that same cycle SHALL win (go to LOAD_FIRST_DATA, no pulse).
REQ-037 Without ROUTER_WAIT_TIMEOUT_EN, WAIT_TILL_EMPTY SHALL wait indefinitely, no counter SHALL exist, timeout_err SHALL be tied 0.

Verification
REQ-038 NUM_CH=3, addr=1, fifo_empty=3'b111, 4-byte packet -> DECODE,LFD,LD x3,LP,CPE,DECODE; ch_sel=3'b010; write_enb_reg high 5 cycles.
REQ-039 addr=3 (NUM_CH=3), pkt_valid high 6 cycles -> DROP_PACKET 6 cycles, write_enb_reg=0, busy=0, return to DECODE.
REQ-040 addr=2, fifo_empty[2]=0 for 10 cycles, addr changed to 0 meanwhile -> WAIT 10 cycles, then LFD with ch_sel=3'b100.
REQ-041 fifo_full=1 during LD for 3 cycles, then low_pkt_valid=1 -> FFS x3, LAF, LP, CPE.
REQ-042 ROUTER_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=4, FIFO never empties -> timeout_err one pulse after 4 WAIT cycles, then DROP_PACKET.
REQ-043 soft_reset[0] during LD on channel 1 -> no effect; soft_reset[1] -> DECODE next cycle, ch_sel=0.
